// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with square/pulse output modes.
// Ratio and mode changes are shadowed and applied only at a period boundary.
module clock_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             mode,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic [WIDTH-1:0] ratio_active
);

    localparam int               DEF_I = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEF_I);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] n);
        return (n < TWO) ? TWO : n;
    endfunction

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] na;
    logic             ma;
    logic [WIDTH-1:0] ns;
    logic             ms;
    logic             pending;

    logic             last;
    logic             boundary;
    logic             apply;
    logic [WIDTH-1:0] new_n;
    logic             new_m;
    logic [WIDTH-1:0] per_n;
    logic             per_m;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] high_len;
    logic             out_next;

    assign ratio_active = na;

    // A load on the boundary edge bypasses the shadow registers.
    always_comb begin
        last     = (cnt == na - ONE);
        boundary = enable && last;
        apply    = boundary && (load || pending);
        new_n    = load ? clamp(div_ratio) : ns;
        new_m    = load ? mode : ms;
        per_n    = apply ? new_n : na;
        per_m    = apply ? new_m : ma;
        cnt_next = last ? '0 : cnt + ONE;
        high_len = per_n - (per_n >> 1);
        out_next = per_m ? (cnt_next == '0) : (cnt_next < high_len);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= DEF_N - ONE;
            na       <= DEF_N;
            ma       <= 1'b0;
            ns       <= DEF_N;
            ms       <= 1'b0;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            if (load) begin
                ns      <= clamp(div_ratio);
                ms      <= mode;
                pending <= 1'b1;
            end
            if (enable) begin
                cnt      <= cnt_next;
                clk_out  <= out_next;
                tick     <= boundary;
                load_ack <= apply;
                if (apply) begin
                    na      <= new_n;
                    ma      <= new_m;
                    pending <= 1'b0;
                end
            end else begin
                tick     <= 1'b0;
                load_ack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog against a period-pattern model.
module tb_clock_divider_prog;

    localparam int W   = 8;
    localparam int DEF = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [W-1:0] div_ratio;
    logic         mode;
    logic         load;
    logic         clk_out;
    logic         tick;
    logic         load_ack;
    logic [W-1:0] ratio_active;

    always #5 clk = ~clk;

    clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div_ratio   (div_ratio),
        .mode        (mode),
        .load        (load),
        .clk_out     (clk_out),
        .tick        (tick),
        .load_ack    (load_ack),
        .ratio_active(ratio_active)
    );

    typedef struct packed {
        logic         out;
        logic         tck;
        logic         ack;
        logic [W-1:0] ratio;
    } exp_t;

    typedef struct packed {
        logic out;
        logic tck;
        logic ack;
    } slot_t;

    exp_t  sb[$];
    slot_t pat[$];

    int checks = 0;
    int passes = 0;

    int  m_n;
    bit  m_mode;
    int  sh_n;
    bit  sh_mode;
    bit  pend;
    bit  last_out;

    function automatic int clampi(input int n);
        return (n < 2) ? 2 : n;
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Build the whole period as a list of per-cycle output values.
    task automatic start_period(input bit acked);
        int h;
        slot_t s;
        h = (m_n + 1) / 2;
        for (int i = 0; i < m_n; i++) begin
            s.out = m_mode ? (i == 0) : (i < h);
            s.tck = (i == 0);
            s.ack = (i == 0) && acked;
            pat.push_back(s);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit ld,
                        input int ratio, input bit md);
        exp_t  e;
        slot_t s;
        bit    acked;
        reset     = rst;
        enable    = en;
        load      = ld;
        div_ratio = W'(ratio);
        mode      = md;
        if (!rst) begin
            m_n = DEF; m_mode = 0; pend = 0; last_out = 0;
            pat.delete();
            e = '{out: 1'b0, tck: 1'b0, ack: 1'b0, ratio: W'(DEF)};
        end else if (en) begin
            if (pat.size() == 0) begin
                acked = 0;
                if (ld) begin
                    m_n = clampi(ratio); m_mode = md; acked = 1; pend = 0;
                end else if (pend) begin
                    m_n = sh_n; m_mode = sh_mode; acked = 1; pend = 0;
                end
                start_period(acked);
            end else if (ld) begin
                sh_n = clampi(ratio); sh_mode = md; pend = 1;
            end
            s = pat.pop_front();
            last_out = s.out;
            e = '{out: s.out, tck: s.tck, ack: s.ack, ratio: W'(m_n)};
        end else begin
            if (ld) begin
                sh_n = clampi(ratio); sh_mode = md; pend = 1;
            end
            e = '{out: last_out, tck: 1'b0, ack: 1'b0, ratio: W'(m_n)};
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("clk_out", int'(clk_out), int'(e.out));
            cmp("tick", int'(tick), int'(e.tck));
            cmp("load_ack", int'(load_ack), int'(e.ack));
            cmp("ratio_active", int'(ratio_active), int'(e.ratio));
        end
    end

    initial begin
        int r;
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 9, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 5, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 3, 1);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 3, 1);
        step(1, 1, 1, 255, 0);
        for (int i = 0; i < 520; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 4, 0);
        for (int i = 0; i < 260; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, (i == 1), 6, 1);
        for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 7, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                            : $urandom_range(0, 9);
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 6) != 0),
                 ($urandom_range(0, 11) == 0),
                 r, 1'($urandom_range(0, 1)));
        end
        step(1, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        cmp("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Runtime-programmable clock divider: the parametrised successor to the fixed-ratio `clock_divider`. It divides `clk` by a ratio N loaded at run time and offers two output modes: square wave and single-cycle pulse. Ratio and mode changes are shadowed and applied only at an output-period boundary, so `clk_out` never glitches. A per-period `tick` strobe drives downstream timers and enables on the `clk` domain. All outputs are registers on `clk`; `clk_out` is a divided enable/clock source, not a gated clock.

## Interface
Parameters:
- `WIDTH`, 8: width of the ratio field; legal N is 2 .. 2^WIDTH-1.
- `DEFAULT_DIV`, 4: ratio after reset; clamped to 2 if below 2.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `enable`  input  1  count enable; when 0, the divider freezes.
- `div_ratio`  input  WIDTH  requested ratio N; sampled when `load`=1.
- `mode`  input  1  requested mode, sampled with `load`: 0 = square, 1 = pulse.
- `load`  input  1  one-cycle request to capture `div_ratio` and `mode`.
- `clk_out`  output  1  divided output.
- `tick`  output  1  1 for one cycle at the start of every output period.
- `load_ack`  output  1  1 for one cycle when a captured request takes effect.
- `ratio_active`  output  WIDTH  ratio currently in force.

## Operation
- **State:**
  - period counter `cnt` (WIDTH bits);
  - active ratio Na and active mode Ma;
  - shadow ratio Ns and shadow mode Ms;
  - `pending` flag.
- **Clamp:** a requested N of 0 or 1 is stored as 2. There is no other range check.
- **Count step** (edge with `enable`=1): `cnt_next` = 0 if `cnt` == Na-1, else `cnt`+1. An edge where `cnt_next` = 0 is a *boundary*.
- **Output function:** let H = N - floor(N/2), i.e. ceil(N/2), using the ratio in force for the new period.
  - Square mode: `clk_out` <= (`cnt_next` < H). High for H cycles, low for floor(N/2). Odd N gives high 1 cycle longer than low.
  - Pulse mode: `clk_out` <= (`cnt_next` == 0).
- **Tick:** `tick` <= boundary AND `enable`. `tick` is 0 on every edge with `enable`=0.
- **Load capture:** on `load`=1, Ns <= clamp(`div_ratio`), Ms <= `mode`, `pending` <= 1.
  - Multiple loads before a boundary: last one wins; only one `load_ack` is issued.
- **Apply:** at a boundary with `pending`=1:
  - Na <= Ns, Ma <= Ms;
  - `pending` <= 0;
  - `load_ack` <= 1, in the same edge as `tick`.
  - The new period's `clk_out` value is computed with the new Na/Ma.
  - The old period always completes at its old length.
- **Load coinciding with a boundary:** the incoming `div_ratio`/`mode` bypass the shadow and apply at that same boundary, with `load_ack`=1.
- **`enable`=0:** `cnt`, `clk_out`, Na and Ma hold; `tick` and `load_ack` are 0. Loads are still captured. No boundary can occur.
- **`ratio_active` = Na** at all times.

## Timing
- **Reset** (`reset`=0 at a rising edge):
  - `cnt` <= clamp(`DEFAULT_DIV`)-1;
  - Na <= clamp(`DEFAULT_DIV`), Ma <= 0;
  - `pending` <= 0, and any pending request is discarded;
  - outputs: `clk_out`=0, `tick`=0, `load_ack`=0, `ratio_active`=clamp(`DEFAULT_DIV`).
- **Reset has priority** over `load` and `enable`. Reset mid-period aborts the period immediately.
- **First period after reset:** the first edge with `reset`=1 and `enable`=1 is a boundary: `cnt`=0, `clk_out`=1, `tick`=1. No shortened or glitched first period.
- **Output latency:** `clk_out`, `tick` and `load_ack` are registered and change only on rising `clk` edges. They change in the same edge as `cnt` updates; there is no extra pipeline stage.
- **Load-to-effect latency:** from the `load` edge to the next boundary, between 0 and Na-1 enabled cycles. `load_ack` always coincides with `tick`.
- **Output period:** exactly Na enabled cycles. Duty is exact to one cycle, with no drift over wrap-around.

## Test plan
1. **Reset, then `enable`=1,** with `DEFAULT_DIV`=4 and a 10 ns clk: `clk_out` = 1,1,0,0 repeating (40 ns period). `tick`=1 on each first cycle. `ratio_active`=4.
2. **Load N=5, mode=0 at `cnt`=1:** the current period completes as 1,1,0,0. Following periods are 1,1,1,0,0. `load_ack` and `tick` go high together on the first 1. `ratio_active`=5 from that edge.
3. **Load N=0, then load N=3, mode=1, then load N=255** before the same boundary, all below 2 or legal:
   - N=0 alone: clamped to 2, giving `clk_out` 1,0 repeating.
   - N=3, mode=1: pattern 1,0,0 with `clk_out` == `tick`.
   - Loading N=255: only N=255 applies, with a single `load_ack`.
4. **Load asserted on a boundary edge:** the new ratio applies in that same period, and `load_ack`=1 on that edge.
5. **`enable`=0 for 3 cycles at `cnt`=1, N=4:**
   - `clk_out` holds 1; `tick`=0 throughout.
   - On resume, the remaining period is 1 high cycle then 0,0.
   - A `load` captured while disabled applies at the next boundary.
6. **`reset`=0 mid-period with `pending`=1:**
   - Outputs go to reset values.
   - After release, the pattern is 1,1,0,0 with N=4.
   - No `load_ack` is ever issued for the discarded request.
